// File: rtl/reduce_tree_pipe.sv
// Pipelined OR/AND/XOR reduction across N_INPUTS channels, one register stage per tree level.
// Latency ceil(log2(N_INPUTS)) cycles; one global enable holds every stage, bubbles included, while the output is blocked.
module reduce_tree_pipe #(
    parameter int N_INPUTS   = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [1:0]                     in_op,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data
);
    localparam int LEVELS = $clog2(N_INPUTS);
    localparam int TREE_W = 1 << LEVELS;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    function automatic logic [DATA_WIDTH-1:0] combine(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        case (op)
            OP_AND:  combine = a & b;
            OP_XOR:  combine = a ^ b;
            default: combine = a | b;
        endcase
    endfunction

    logic                         en;
    logic [TREE_W*DATA_WIDTH-1:0] leaf;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Unused leaves take the identity of this beat's op: ones for AND, zeros otherwise.
    always_comb begin
        leaf = {(TREE_W*DATA_WIDTH){in_op == OP_AND}};
        leaf[N_INPUTS*DATA_WIDTH-1:0] = in_data;
    end

    for (genvar g = 1; g <= LEVELS; g++) begin : g_lvl
        localparam int NW = TREE_W >> g;

        logic [2*NW*DATA_WIDTH-1:0] src_dat;
        logic                       src_vld;
        logic [1:0]                 src_op;
        logic [NW*DATA_WIDTH-1:0]   dat_d;
        logic [NW*DATA_WIDTH-1:0]   dat_q;
        logic                       vld_d;
        logic                       vld_q;

        if (g == 1) begin : g_src
            assign src_dat = leaf;
            assign src_vld = in_valid;
            assign src_op  = in_op;
        end else begin : g_src
            assign src_dat = g_lvl[g-1].dat_q;
            assign src_vld = g_lvl[g-1].vld_q;
            assign src_op  = g_lvl[g-1].g_op.op_q;
        end

        // Bubbles load zeros so out_data never shows leftovers of a discarded or drained beat.
        always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            if (en) begin
                vld_d = src_vld;
                dat_d = '0;
                if (src_vld) begin
                    for (int i = 0; i < NW; i++) begin
                        dat_d[i*DATA_WIDTH +: DATA_WIDTH] =
                            combine(src_op,
                                    src_dat[(2*i)*DATA_WIDTH +: DATA_WIDTH],
                                    src_dat[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        // The op travels with the partials; the output stage has no consumer for it.
        if (g < LEVELS) begin : g_op
            logic [1:0] op_d;
            logic [1:0] op_q;

            always_comb begin
                op_d = op_q;
                if (en) begin
                    op_d = src_vld ? src_op : 2'b00;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_q <= 2'b00;
                end else begin
                    op_q <= op_d;
                end
            end
        end
    end

    assign out_valid = g_lvl[LEVELS].vld_q;
    assign out_data  = g_lvl[LEVELS].dat_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed and random checks of reduce_tree_pipe at N=8/DW=1 and N=5/DW=4.
module tb_reduce_tree_pipe;
    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_op;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [0:0]  a_out_data;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [19:0] b_in_data;
    logic [1:0]  b_in_op;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [3:0]  b_out_data;

    int tests_run;
    int tests_failed;

    reduce_tree_pipe #(.N_INPUTS(8), .DATA_WIDTH(1)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    reduce_tree_pipe #(.N_INPUTS(5), .DATA_WIDTH(4)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    always #5 clk = ~clk;

    function automatic logic ref_reduce8(input logic [1:0] op, input logic [7:0] d);
        case (op)
            2'b01:   ref_reduce8 = &d;
            2'b10:   ref_reduce8 = ^d;
            default: ref_reduce8 = |d;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset;
        #12;
        tests_run++;
        if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        tests_run++;
        if (a_out_data !== 1'b0) begin tests_failed++; $display("FAIL reset_out_data: got %b want 0", a_out_data); end
        tests_run++;
        if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        tests_run++;
        if (b_out_valid !== 1'b0 || b_out_data !== 4'h0) begin
            tests_failed++; $display("FAIL reset_n5: got valid %b data %h want 0/0", b_out_valid, b_out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_or_and_xor_stream;
        logic [1:0] ops[4];
        logic [7:0] dats[4];
        logic       res[4];
        logic       exp_vld;
        ops  = '{2'b00, 2'b01, 2'b01, 2'b10};
        dats = '{8'h01, 8'hFF, 8'hFE, 8'h07};
        res  = '{1'b1, 1'b1, 1'b0, 1'b1};
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            exp_vld = (cyc >= 3 && cyc <= 6);
            tests_run++;
            if (a_out_valid !== exp_vld) begin
                tests_failed++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, a_out_valid, exp_vld);
            end
            if (exp_vld) begin
                tests_run++;
                if (a_out_data !== res[cyc-3]) begin
                    tests_failed++; $display("FAIL stream_data c%0d: got %b want %b", cyc, a_out_data, res[cyc-3]);
                end
            end
            if (cyc < 4) begin
                a_in_valid = 1'b1;
                a_in_op    = ops[cyc];
                a_in_data  = dats[cyc];
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        idle_cycles(3);
    endtask

    task automatic test_reserved_op;
        logic [7:0] dats[3];
        logic       res[3];
        dats = '{8'h80, 8'h81, 8'h00};
        res  = '{1'b1, 1'b1, 1'b0};
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc >= 3 && cyc <= 5) begin
                tests_run++;
                if (a_out_valid !== 1'b1 || a_out_data !== res[cyc-3]) begin
                    tests_failed++;
                    $display("FAIL reserved_op c%0d: got valid %b data %b want 1/%b", cyc, a_out_valid, a_out_data, res[cyc-3]);
                end
            end
            if (cyc < 3) begin
                a_in_valid = 1'b1;
                a_in_op    = 2'b11;
                a_in_data  = dats[cyc];
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        idle_cycles(3);
    endtask

    task automatic test_backpressure_capacity;
        logic [1:0] ops[5];
        logic [7:0] dats[5];
        logic       res[5];
        int         idx;
        int         nout;
        ops  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        dats = '{8'h10, 8'hEF, 8'h0B, 8'hFF, 8'h11};
        res  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        idx  = 0;
        nout = 0;
        a_out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tests_run++;
            if (a_out_valid !== (cyc >= 3)) begin
                tests_failed++; $display("FAIL cap_valid c%0d: got %b want %b", cyc, a_out_valid, cyc >= 3);
            end
            if (cyc >= 3) begin
                tests_run++;
                if (a_out_data !== res[0]) begin
                    tests_failed++; $display("FAIL cap_hold_data c%0d: got %b want %b", cyc, a_out_data, res[0]);
                end
            end
            a_in_valid = 1'b1;
            a_in_op    = ops[idx];
            a_in_data  = dats[idx];
            #1;
            tests_run++;
            if (a_in_ready !== (cyc < 3)) begin
                tests_failed++; $display("FAIL cap_in_ready c%0d: got %b want %b", cyc, a_in_ready, cyc < 3);
            end
            if (a_in_ready) idx++;
            tick();
        end
        tests_run++;
        if (idx != 3) begin tests_failed++; $display("FAIL cap_accepted: got %0d want 3", idx); end
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (idx < 5) begin
                a_in_valid = 1'b1;
                a_in_op    = ops[idx];
                a_in_data  = dats[idx];
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (a_in_valid && a_in_ready) idx++;
            if (a_out_valid && a_out_ready) begin
                tests_run++;
                if (nout >= 5) begin
                    tests_failed++; $display("FAIL drain_extra: got beat %0d want none", nout);
                end else if (a_out_data !== res[nout]) begin
                    tests_failed++; $display("FAIL drain_data b%0d: got %b want %b", nout, a_out_data, res[nout]);
                end
                nout++;
            end
            tick();
        end
        tests_run++;
        if (nout != 5 || idx != 5) begin
            tests_failed++; $display("FAIL drain_count: got out %0d in %0d want 5/5", nout, idx);
        end
        idle_cycles(2);
    endtask

    task automatic test_padding_n5;
        logic [1:0]  ops[4];
        logic [19:0] dats[4];
        logic [3:0]  res[4];
        ops  = '{2'b01, 2'b10, 2'b01, 2'b00};
        dats = '{20'hFFFFF, 20'h08421, 20'hFFFF5, 20'h00003};
        res  = '{4'hF, 4'hF, 4'h5, 4'h3};
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tests_run++;
            if (b_out_valid !== (cyc >= 3 && cyc <= 6)) begin
                tests_failed++; $display("FAIL pad_valid c%0d: got %b", cyc, b_out_valid);
            end
            if (cyc >= 3 && cyc <= 6) begin
                tests_run++;
                if (b_out_data !== res[cyc-3]) begin
                    tests_failed++; $display("FAIL pad_data c%0d: got %h want %h", cyc, b_out_data, res[cyc-3]);
                end
            end
            if (cyc < 4) begin
                b_in_valid = 1'b1;
                b_in_op    = ops[cyc];
                b_in_data  = dats[cyc];
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_flight;
        a_out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            a_in_valid = 1'b1;
            a_in_op    = 2'b00;
            a_in_data  = 8'hFF;
            tick();
        end
        a_in_valid = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_valid: got %b want 1", a_out_valid); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out_data !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async: got valid %b data %b want 0/0", a_out_valid, a_out_data);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            tests_run++;
            if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stale c%0d: got valid %b want 0", cyc, a_out_valid); end
        end
    endtask

    task automatic test_random_stream;
        logic q_exp[$];
        logic e;
        logic prev_stall;
        logic prev_dat;
        int   acc;
        int   cyc;
        acc        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_dat   = 1'b0;
        while ((acc < 1000 || q_exp.size() > 0) && cyc < 30000) begin
            if (prev_stall) begin
                tests_run++;
                if (a_out_valid !== 1'b1 || a_out_data !== prev_dat) begin
                    tests_failed++;
                    $display("FAIL rand_stall c%0d: got valid %b data %b want 1/%b", cyc, a_out_valid, a_out_data, prev_dat);
                end
            end
            a_in_valid  = (acc < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a_in_op     = 2'($urandom_range(0, 3));
            a_in_data   = 8'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            tests_run++;
            if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
                tests_failed++; $display("FAIL rand_in_ready c%0d: got %b", cyc, a_in_ready);
            end
            if (a_out_valid && a_out_ready) begin
                tests_run++;
                if (q_exp.size() == 0) begin
                    tests_failed++; $display("FAIL rand_spurious c%0d: got %b want no beat", cyc, a_out_data);
                end else begin
                    e = q_exp.pop_front();
                    if (a_out_data !== e) begin
                        tests_failed++; $display("FAIL rand_data c%0d: got %b want %b", cyc, a_out_data, e);
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                q_exp.push_back(ref_reduce8(a_in_op, a_in_data));
                acc++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev_dat   = a_out_data;
            tick();
            cyc++;
        end
        tests_run++;
        if (acc != 1000 || q_exp.size() != 0) begin
            tests_failed++; $display("FAIL rand_complete: got accepted %0d pending %0d want 1000/0", acc, q_exp.size());
        end
        idle_cycles(2);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        a_in_valid   = 1'b0;
        a_in_data    = 8'h00;
        a_in_op      = 2'b00;
        a_out_ready  = 1'b0;
        b_in_valid   = 1'b0;
        b_in_data    = 20'h0;
        b_in_op      = 2'b00;
        b_out_ready  = 1'b0;

        test_reset();
        test_or_and_xor_stream();
        test_reserved_op();
        test_backpressure_capacity();
        test_padding_n5();
        test_reset_mid_flight();
        test_random_stream();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reduce_tree_pipe.md
# reduce_tree_pipe

Parametrised, pipelined bitwise reduction tree that replaces cascaded two-input gate chains with a balanced tree of depth ceil(log2(N_INPUTS)), one register stage per tree level. Supports run-time selection of OR, AND or XOR reduction across N_INPUTS channels of DATA_WIDTH bits each. Uses valid/ready handshakes on both sides, so it drops into streaming datapaths as the high-fan-in combine stage.

## Interface
- N_INPUTS, 8, number of input channels; legal range 2..64.
- DATA_WIDTH, 1, bits per channel; the reduction is bitwise across channels.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  N_INPUTS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_op  in  2  operation: 00 OR, 01 AND, 10 XOR, 11 reserved, executed as OR.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  reduced result.

## Operation
- Depth: L = ceil(log2(N_INPUTS)). Examples: N=8 gives L=3, N=5 gives L=3, N=2 gives L=1.
- Padding: the tree width is 2^L. Unused leaf inputs are tied to the identity element of the operation carried by that beat:
  - OR and XOR: all zeros.
  - AND: all ones.
- Each stage register holds:
  - a valid bit;
  - the 2-bit op, latched with the data and travelling alongside it;
  - the partial results for that level.
- in_op is sampled only on acceptance. Beats with different ops may be in flight simultaneously; each beat is reduced with its own op.
- Stage L is the output register and drives out_valid and out_data directly.
- Global enable: en = !out_valid || out_ready.
  - in_ready = en, so it depends combinationally on out_valid and out_ready only, never on in_valid.
  - When en = 1, every stage shifts forward. Stage 1 loads the level-1 results with valid = in_valid.
  - When en = 0, every stage holds, including bubbles. Bubbles are not collapsed.
- Acceptance occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Reset: all valid bits, op fields, data registers and out_data go to 0. After reset, out_valid = 0 and in_ready = 1.
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronously). No partial result is emitted afterwards.

## Timing
- Latency: a beat accepted in cycle c presents out_valid = 1 with its result in cycle c+L, provided no stall occurred in between.
- Throughput: one beat per cycle while out_ready = 1.
- Capacity: the pipeline holds at most L beats. With out_ready held at 0 from reset, exactly L beats are accepted; in_ready falls in the cycle out_valid first rises.
- Stall: while out_valid && !out_ready, out_data, the op fields and all stage contents stay stable.
- Simultaneous events: a transfer and an acceptance in the same cycle are both legal. The pipeline advances by one stage.
- Boundary: N_INPUTS a power of two means no padding. N_INPUTS = 2 gives a single register stage.

## Test plan
- Case 1: N=8, DW=1, out_ready=1. Inputs: OR with in_data=8'h01, then AND with 8'hFF, then AND with 8'hFE, then XOR with 8'h07, on consecutive cycles starting at cycle 0. Required: out_data = 1, 1, 0, 1 with out_valid high in cycles 3, 4, 5, 6.
- Case 2: N=8, out_ready=0, in_valid=1 continuously with 5 distinct beats. Required:
  - only beats 1–3 are accepted; in_ready = 0 from cycle 3;
  - out_data stays at beat 1's result;
  - after out_ready rises, results for beats 1–5 appear in order with no loss or duplication.
- Case 3: N=5, DW=4, AND with all channels 4'hF. Required: out_data = 4'hF, confirming all-ones padding. Then XOR with channels {1,2,4,8,0}. Required: out_data = 4'hF, confirming zero padding.
- Case 4: in_op = 11 with in_data = 8'h80. Required: out_data = 1, i.e. executed as OR.
- Case 5: with 3 beats in flight, assert rst for one cycle. Required: out_valid = 0 immediately, out_data = 0, in_ready = 1 after release, and no stale result ever appears.
- Case 6: random stream of 1000 beats with random in_valid, out_ready and ops. Required: scoreboard matches the reference reduction in order and valid never drops while stalled.
